// File: rtl/clk_tick_if.sv
// Control/write bus and per-channel outputs of the clock-enable generator.
// The generator drives tick/sq/pend; the controller drives the rest.
interface clk_tick_if #(
  parameter int unsigned NCH = 2,
  parameter int unsigned CW  = 18
) ();
  localparam int unsigned SW = (NCH > 1) ? $clog2(NCH) : 1;

  logic           run;
  logic           restart;
  logic           div_we;
  logic [SW-1:0]  div_sel;
  logic [CW-1:0]  div_val;
  logic [NCH-1:0] tick;
  logic [NCH-1:0] sq;
  logic [NCH-1:0] pend;

  modport master (
    output run, restart, div_we, div_sel, div_val,
    input  tick, sq, pend
  );

  modport slave (
    input  run, restart, div_we, div_sel, div_val,
    output tick, sq, pend
  );
endinterface

// File: rtl/clk_tick_gen.sv
// Multi-channel programmable clock-enable generator: per-channel one-cycle tick strobe and
// near-50% square wave, with shadowed divisors that only take effect at a period boundary.
module clk_tick_gen #(
  parameter int unsigned          NCH      = 2,
  parameter int unsigned          CW       = 18,
  parameter logic [NCH*CW-1:0]    DIV_INIT = {18'd131072, 18'd2}
) (
  input  logic     clk,
  input  logic     clr_n,
  clk_tick_if.slave bus
);
  localparam int unsigned SW = (NCH > 1) ? $clog2(NCH) : 1;

  logic [NCH-1:0] tick_v;
  logic [NCH-1:0] sq_v;
  logic [NCH-1:0] pend_v;

  for (genvar i = 0; i < NCH; i++) begin : g_ch
    localparam logic [CW-1:0] Init = DIV_INIT[i*CW +: CW];

    logic [CW-1:0] cnt_q, cnt_d;
    logic [CW-1:0] act_q, act_d;
    logic [CW-1:0] shd_q, shd_d;
    logic          pend_q, pend_d;
    logic          tick_q, tick_d;
    logic          sq_q, sq_d;
    logic          wr;

    // Out-of-range selects match no channel, so they are silently dropped.
    assign wr = bus.div_we && (bus.div_sel == SW'(i));

    always_comb begin
      cnt_d  = cnt_q;
      act_d  = act_q;
      shd_d  = shd_q;
      pend_d = pend_q;
      tick_d = 1'b0;
      sq_d   = sq_q;
      if (wr) begin
        shd_d  = bus.div_val;
        pend_d = 1'b1;
      end
      if (bus.restart || (act_q == '0)) begin
        // No period to protect: apply any pending divisor immediately.
        cnt_d = '0;
        sq_d  = 1'b0;
        if (pend_q) begin
          act_d = shd_q;
          if (!wr) pend_d = 1'b0;
        end
      end else if (bus.run) begin
        if (cnt_q == act_q - CW'(1)) begin
          cnt_d  = '0;
          tick_d = 1'b1;
          // A same-cycle write beats an older pending shadow value.
          if (wr) begin
            act_d  = bus.div_val;
            pend_d = 1'b0;
          end else if (pend_q) begin
            act_d  = shd_q;
            pend_d = 1'b0;
          end
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
        sq_d = (cnt_d >= (act_d >> 1));
      end
    end

    always_ff @(posedge clk or negedge clr_n) begin
      if (!clr_n) begin
        cnt_q  <= '0;
        act_q  <= Init;
        shd_q  <= Init;
        pend_q <= 1'b0;
        tick_q <= 1'b0;
        sq_q   <= 1'b0;
      end else begin
        cnt_q  <= cnt_d;
        act_q  <= act_d;
        shd_q  <= shd_d;
        pend_q <= pend_d;
        tick_q <= tick_d;
        sq_q   <= sq_d;
      end
    end

    assign tick_v[i] = tick_q;
    assign sq_v[i]   = sq_q;
    assign pend_v[i] = pend_q;
  end

  assign bus.tick = tick_v;
  assign bus.sq   = sq_v;
  assign bus.pend = pend_v;
endmodule

// File: tb/tb_clk_tick_gen.sv
// Randomized bench for clk_tick_gen: integer reference model, per-cycle compare,
// independent tick-interval checker and hand-computed directed expectations.
module tb_clk_tick_gen;
  localparam int unsigned NCH = 3;
  localparam int unsigned CW  = 18;
  localparam logic [NCH*CW-1:0] DIV_INIT = {18'd7, 18'd37, 18'd2};

  logic clk   = 1'b0;
  logic clr_n = 1'b0;
  always #5 clk = ~clk;

  clk_tick_if #(.NCH(NCH), .CW(CW)) bus ();

  clk_tick_gen #(.NCH(NCH), .CW(CW), .DIV_INIT(DIV_INIT)) dut (
    .clk   (clk),
    .clr_n (clr_n),
    .bus   (bus)
  );

  int total = 0;
  int bad   = 0;

  // Model: position within the current period, active/shadow divisor, pending flag.
  int m_pos[NCH];
  int m_act[NCH];
  int m_shd[NCH];
  bit m_pend[NCH];
  bit m_tick[NCH];
  bit m_sq[NCH];
  bit chk_en = 1'b0;

  int since[NCH];
  int plen[NCH];
  bit dirty[NCH];

  task automatic check(input string name, input int got, input int want);
    total++;
    if (got != want) begin
      bad++;
      $display("FAIL %s @%0t: got %0d want %0d", name, $time, got, want);
    end
  endtask

  function automatic int init_div(input int ch);
    logic [NCH*CW-1:0] v;
    v = DIV_INIT;
    return int'(v[ch*CW +: CW]);
  endfunction

  task automatic model_reset();
    for (int ch = 0; ch < NCH; ch++) begin
      m_pos[ch]  = 0;
      m_act[ch]  = init_div(ch);
      m_shd[ch]  = m_act[ch];
      m_pend[ch] = 1'b0;
      m_tick[ch] = 1'b0;
      m_sq[ch]   = 1'b0;
    end
  endtask

  task automatic model_step();
    if (!clr_n) begin
      model_reset();
    end else begin
      for (int ch = 0; ch < NCH; ch++) begin
        bit wr;
        int v;
        wr = bus.div_we && (int'(bus.div_sel) == ch);
        v  = int'(bus.div_val);
        if (bus.restart || m_act[ch] == 0) begin
          m_pos[ch] = 0; m_tick[ch] = 1'b0; m_sq[ch] = 1'b0;
          if (m_pend[ch]) begin m_act[ch] = m_shd[ch]; m_pend[ch] = 1'b0; end
          if (wr) begin m_shd[ch] = v; m_pend[ch] = 1'b1; end
        end else if (!bus.run) begin
          m_tick[ch] = 1'b0;
          if (wr) begin m_shd[ch] = v; m_pend[ch] = 1'b1; end
        end else begin
          m_pos[ch]  = (m_pos[ch] + 1) % m_act[ch];
          m_tick[ch] = (m_pos[ch] == 0);
          if (m_tick[ch] && wr) begin
            m_act[ch] = v; m_shd[ch] = v; m_pend[ch] = 1'b0;
          end else if (m_tick[ch] && m_pend[ch]) begin
            m_act[ch] = m_shd[ch]; m_pend[ch] = 1'b0;
          end else if (wr) begin
            m_shd[ch] = v; m_pend[ch] = 1'b1;
          end
          // High during the last ceil(act/2) positions of the period.
          m_sq[ch] = (m_pos[ch] >= m_act[ch] - (m_act[ch] + 1) / 2);
        end
      end
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      int et, es, ep;
      et = 0; es = 0; ep = 0;
      for (int ch = 0; ch < NCH; ch++) begin
        et |= int'(m_tick[ch]) << ch;
        es |= int'(m_sq[ch]) << ch;
        ep |= int'(m_pend[ch]) << ch;
      end
      check("tick", int'(bus.tick), et);
      check("sq", int'(bus.sq), es);
      check("pend", int'(bus.pend), ep);
      for (int ch = 0; ch < NCH; ch++) begin
        since[ch]++;
        if (!clr_n || bus.restart || !bus.run || m_act[ch] == 0) dirty[ch] = 1'b1;
        if (bus.tick[ch]) begin
          if (!dirty[ch] && plen[ch] > 0) check("period", since[ch], plen[ch]);
          since[ch] = 0;
          plen[ch]  = m_act[ch];
          dirty[ch] = 1'b0;
        end
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    model_step();
    @(negedge clk);
    #2;
  endtask

  task automatic wr(input int sel, input int val);
    bus.div_we  = 1'b1;
    bus.div_sel = 2'(sel);
    bus.div_val = CW'(val);
  endtask

  initial begin
    int hi;
    bus.run = 1'b1; bus.restart = 1'b0; bus.div_we = 1'b0;
    bus.div_sel = '0; bus.div_val = '0;
    model_reset();
    chk_en = 1'b1;
    repeat (3) cyc();
    check("rst_tick", int'(bus.tick), 0);
    check("rst_sq", int'(bus.sq), 0);
    check("rst_pend", int'(bus.pend), 0);
    clr_n = 1'b1;

    for (int c = 1; c <= 40; c++) begin
      cyc();
      check("t1_tick0", int'(bus.tick[0]), int'(c % 2 == 0));
      check("t1_sq0", int'(bus.sq[0]), c % 2);
      check("t1_tick1", int'(bus.tick[1]), int'(c == 37));
    end

    wr(0, 5); cyc(); bus.div_we = 1'b0;
    check("t2_pend_set", int'(bus.pend[0]), 1);
    cyc();
    check("t2_old_tick", int'(bus.tick[0]), 1);
    check("t2_pend_clr", int'(bus.pend[0]), 0);
    hi = 0;
    for (int k = 1; k <= 10; k++) begin
      cyc();
      check("t2_tick", int'(bus.tick[0]), int'(k % 5 == 0));
      if (k <= 5) hi += int'(bus.sq[0]);
    end
    check("t2_sq_high", hi, 3);

    wr(0, 1); cyc(); bus.div_we = 1'b0;
    repeat (6) cyc();
    for (int k = 1; k <= 4; k++) begin
      cyc();
      check("t3_div1_tick", int'(bus.tick[0]), 1);
      check("t3_div1_sq", int'(bus.sq[0]), 1);
    end
    wr(0, 0); cyc(); bus.div_we = 1'b0;
    cyc();
    check("t3_div0_tick", int'(bus.tick[0]), 0);
    check("t3_div0_sq", int'(bus.sq[0]), 0);
    wr(0, 3); cyc(); bus.div_we = 1'b0;
    check("t3_div3_pend", int'(bus.pend[0]), 1);
    for (int k = 1; k <= 7; k++) begin
      cyc();
      check("t3_div3_tick", int'(bus.tick[0]), int'(k == 4 || k == 7));
    end

    cyc();
    bus.run = 1'b0;
    for (int k = 1; k <= 7; k++) begin
      cyc();
      check("t4_hold", int'(bus.tick), 0);
    end
    bus.run = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      cyc();
      check("t4_resume", int'(bus.tick[0]), int'(k == 2));
    end
    bus.restart = 1'b1; cyc(); bus.restart = 1'b0;
    check("t4_rst_tick", int'(bus.tick), 0);
    check("t4_rst_sq", int'(bus.sq), 0);
    for (int k = 1; k <= 3; k++) begin
      cyc();
      check("t4_after", int'(bus.tick[0]), int'(k == 3));
    end

    wr(0, 4); cyc(); bus.div_we = 1'b0;
    cyc();
    wr(0, 6); cyc(); bus.div_we = 1'b0;
    check("t5_wrap_tick", int'(bus.tick[0]), 1);
    check("t5_wrap_pend", int'(bus.pend[0]), 0);
    for (int k = 1; k <= 6; k++) begin
      cyc();
      check("t5_period6", int'(bus.tick[0]), int'(k == 6));
    end
    wr(3, 9); cyc(); bus.div_we = 1'b0;
    check("t5_badsel", int'(bus.pend), 0);

    wr(1, 11); cyc(); bus.div_we = 1'b0;
    check("t6_pend1", int'(bus.pend[1]), 1);
    cyc();
    clr_n = 1'b0;
    #1;
    check("t6_tick", int'(bus.tick), 0);
    check("t6_sq", int'(bus.sq), 0);
    check("t6_pend", int'(bus.pend), 0);
    model_reset();
    cyc(); cyc();
    clr_n = 1'b1;
    for (int c = 1; c <= 4; c++) begin
      cyc();
      check("t6_init_div", int'(bus.tick[0]), int'(c % 2 == 0));
    end

    for (int n = 0; n < 3000; n++) begin
      bus.run     = ($urandom_range(0, 15) != 0);
      bus.restart = ($urandom_range(0, 63) == 0);
      bus.div_we  = ($urandom_range(0, 7) == 0);
      bus.div_sel = 2'($urandom_range(0, 3));
      bus.div_val = CW'($urandom_range(0, 11));
      clr_n       = ($urandom_range(0, 599) != 0);
      cyc();
    end
    clr_n = 1'b1;
    bus.run = 1'b1; bus.restart = 1'b0; bus.div_we = 1'b0;
    repeat (20) cyc();

    chk_en = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
